// File: rtl/carry_select_subtractor_seq.sv
// ---------------------------------------------------------------------------
// carry_select_subtractor_seq
//
// Multi-cycle unsigned subtractor: Diff = (A - B - bin) mod 2^WIDTH, with
// borrow out BO = 1 when A < B + bin. The subtraction is done as
// A + ~B + ~bin. One BLOCK-bit carry-select slice is resolved per clock,
// LSB slice first, so WIDTH/BLOCK cycles are spent in CALC.
// WIDTH must be a multiple of BLOCK.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, dominant over everything
//   start in   operation request, sampled only while busy=0
//   A     in   minuend,    captured on an accepted start
//   B     in   subtrahend, captured on an accepted start
//   bin   in   borrow in,  captured on an accepted start
//   busy  out  high while slices are being computed
//   done  out  one-cycle pulse when Diff/BO are valid
//   Diff  out  result, held until the next accepted start
//   BO    out  borrow out, held until the next accepted start
// ---------------------------------------------------------------------------
module carry_select_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             BO
);

    localparam int N    = WIDTH / BLOCK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic              carry_q;
    logic              bo_q;
    logic [IDXW-1:0]   idx_q;

    logic              accept;
    logic              last_slice;
    logic [BLOCK-1:0]  a_slice;
    logic [BLOCK-1:0]  nb_slice;
    logic [BLOCK:0]    sum0;
    logic [BLOCK:0]    sum1;
    logic [BLOCK-1:0]  sel_sum;
    logic              sel_carry;

    // A new operation can be taken from IDLE or straight out of DONE.
    assign accept     = start && (state_q != CALC);
    assign last_slice = (idx_q == IDXW'(N - 1));

    // Both candidate slice sums are formed up front; the registered carry
    // from the previous slice only picks one of them.
    assign a_slice  = a_q[idx_q*BLOCK +: BLOCK];
    assign nb_slice = ~b_q[idx_q*BLOCK +: BLOCK];
    assign sum0     = {1'b0, a_slice} + {1'b0, nb_slice};
    assign sum1     = {1'b0, a_slice} + {1'b0, nb_slice} + {{BLOCK{1'b0}}, 1'b1};
    assign sel_sum   = carry_q ? sum1[BLOCK-1:0] : sum0[BLOCK-1:0];
    assign sel_carry = carry_q ? sum1[BLOCK]     : sum0[BLOCK];

    // NOTE: every signal written in a combinational block gets a default
    // before the case statement, otherwise an unassigned path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_slice) state_d = DONE;
            DONE:    state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            bo_q    <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= ~bin;
            idx_q   <= '0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else if (state_q == CALC) begin
            diff_q[idx_q*BLOCK +: BLOCK] <= sel_sum;
            carry_q <= sel_carry;
            idx_q   <= idx_q + 1'b1;
            // Borrow is the inverse of the final carry of A + ~B + ~bin.
            if (last_slice) begin
                bo_q <= ~sel_carry;
            end
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign BO   = bo_q;

endmodule
